std_div_iter: RTL and testbench

//  Iterative multi-cycle integer divider producing quotient and remainder.

---
 rtl/std_div_pkg.sv | 20 ++
 rtl/std_div_step.sv | 30 +++
 rtl/std_div_iter.sv | 178 +++++++++++++++++
 tb/tb_std_div_iter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/std_div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package std_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   // Number of CALC iterations needed to retire all quotient bits.
   function automatic int div_iters(input int width, input int bpc);
      return width / bpc;
   endfunction

   // Counter width able to hold every value 0..ITERS.
   function automatic int div_cnt_w(input int width, input int bpc);
      return $clog2(div_iters(width, bpc) + 1);
   endfunction

endpackage

// File: rtl/std_div_step.sv
// One restoring division step: shift in the next dividend bit, try to
// subtract the divisor, and shift the resulting quotient bit in at the LSB.
module std_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   shifted_d;
   logic [WIDTH+1:0] diff_d;
   logic             take_d;

   // Compare-and-subtract; a set rem_i MSB means the shifted value surely exceeds the divisor.
   always_comb begin
      shifted_d = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
      diff_d    = {1'b0, shifted_d} - {2'b00, div_i};
      take_d    = rem_i[WIDTH] | ~diff_d[WIDTH+1];
      if (take_d) begin
         rem_o = diff_d[WIDTH:0];
      end else begin
         rem_o = shifted_d;
      end
      quo_o = {quo_i[WIDTH-2:0], take_d};
   end

endmodule

// File: rtl/std_div_iter.sv
// Iterative go/done integer divider: BITS_PER_CYCLE restoring steps per clock,
// optional two's-complement operands, fast exits for zero divisor/dividend.
module std_div_iter
   import std_div_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int SIGNED         = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             done,
   output logic             busy,
   output logic             div_by_zero
);

   localparam int ITERS = div_iters(WIDTH, BITS_PER_CYCLE);
   localparam int CNT_W = div_cnt_w(WIDTH, BITS_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   if (WIDTH < 2) begin : g_chk_width
      $error("std_div_iter: WIDTH must be at least 2");
   end
   if (BITS_PER_CYCLE < 1) begin : g_chk_bpc_min
      $error("std_div_iter: BITS_PER_CYCLE must be at least 1");
   end else if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_chk_bpc_div
      $error("std_div_iter: WIDTH must be a multiple of BITS_PER_CYCLE");
   end

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   rem_q;        // partial remainder
   logic [WIDTH-1:0] quo_q;        // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvs_q;        // divisor magnitude
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] remd_q;
   logic             done_q;
   logic             busy_q;
   logic             dbz_q;

   logic             sl_d;
   logic             sr_d;
   logic [WIDTH-1:0] mag_l_d;
   logic [WIDTH-1:0] mag_r_d;
   logic [WIDTH-1:0] fix_quo_d;
   logic [WIDTH-1:0] fix_rem_d;

   logic [WIDTH:0]   rem_chain [0:BITS_PER_CYCLE];
   logic [WIDTH-1:0] quo_chain [0:BITS_PER_CYCLE];

   assign rem_chain[0] = rem_q;
   assign quo_chain[0] = quo_q;

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
      std_div_step #(.WIDTH(WIDTH)) u_step (
         .rem_i (rem_chain[g]),
         .quo_i (quo_chain[g]),
         .div_i (dvs_q),
         .rem_o (rem_chain[g+1]),
         .quo_o (quo_chain[g+1])
      );
   end

   // Operand signs and magnitudes; MIN maps to 2^(WIDTH-1) as an unsigned value.
   always_comb begin
      if (SIGNED != 0) begin
         sl_d = left[WIDTH-1];
         sr_d = right[WIDTH-1];
      end else begin
         sl_d = 1'b0;
         sr_d = 1'b0;
      end
      if (sl_d) begin
         mag_l_d = -left;
      end else begin
         mag_l_d = left;
      end
      if (sr_d) begin
         mag_r_d = -right;
      end else begin
         mag_r_d = right;
      end
   end

   // Sign correction applied on the FIX edge.
   always_comb begin
      if (neg_quo_q) begin
         fix_quo_d = -quo_q;
      end else begin
         fix_quo_d = quo_q;
      end
      if (neg_rem_q) begin
         fix_rem_d = -rem_q[WIDTH-1:0];
      end else begin
         fix_rem_d = rem_q[WIDTH-1:0];
      end
   end

   // Control FSM and datapath registers, including the registered result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         quot_q    <= '0;
         remd_q    <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (go) begin
                  dbz_q  <= 1'b0;
                  quot_q <= '0;
                  remd_q <= '0;
                  if (right == '0) begin
                     done_q <= 1'b1;
                     dbz_q  <= 1'b1;
                     quot_q <= '1;
                     remd_q <= left;
                  end else if (left == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     rem_q     <= '0;
                     quo_q     <= mag_l_d;
                     dvs_q     <= mag_r_d;
                     neg_quo_q <= sl_d ^ sr_d;
                     neg_rem_q <= sl_d;
                     cnt_q     <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_chain[BITS_PER_CYCLE];
               quo_q <= quo_chain[BITS_PER_CYCLE];
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quot_q  <= fix_quo_d;
               remd_q  <= fix_rem_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_quotient  = quot_q;
   assign out_remainder = remd_q;
   assign done          = done_q;
   assign busy          = busy_q;
   assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_std_div_iter.sv
// Self-checking bench for std_div_iter: an unsigned bpc=1 instance and a
// signed bpc=2 instance, directed cases followed by random pairs against a
// wide-integer arithmetic reference.
module tb_std_div_iter;

   localparam int ITERS_U = 32;
   localparam int ITERS_S = 16;
   localparam int LIMIT   = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic        u_go, s_go;
   logic [31:0] u_left, u_right, s_left, s_right;
   logic [31:0] u_q, u_r, s_q, s_r;
   logic        u_done, u_busy, u_dbz, s_done, s_busy, s_dbz;

   logic        sel;
   logic [31:0] m_q, m_r;
   logic        m_done, m_busy, m_dbz;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   std_div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .SIGNED(0)) dut_u (
      .clk(clk), .reset(reset), .go(u_go), .left(u_left), .right(u_right),
      .out_quotient(u_q), .out_remainder(u_r), .done(u_done), .busy(u_busy),
      .div_by_zero(u_dbz));

   std_div_iter #(.WIDTH(32), .BITS_PER_CYCLE(2), .SIGNED(1)) dut_s (
      .clk(clk), .reset(reset), .go(s_go), .left(s_left), .right(s_right),
      .out_quotient(s_q), .out_remainder(s_r), .done(s_done), .busy(s_busy),
      .div_by_zero(s_dbz));

   assign m_q    = sel ? s_q    : u_q;
   assign m_r    = sel ? s_r    : u_r;
   assign m_done = sel ? s_done : u_done;
   assign m_busy = sel ? s_busy : u_busy;
   assign m_dbz  = sel ? s_dbz  : u_dbz;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit integer division, C-style truncation toward zero.
   task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output bit dz);
      longint la, lb, tq, tr;
      dz = (b == 32'd0);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         if (s) begin
            la = $signed(a);
            lb = $signed(b);
         end else begin
            la = {32'd0, a};
            lb = {32'd0, b};
         end
         tq = la / lb;
         tr = la % lb;
         q  = tq[31:0];
         r  = tr[31:0];
      end
   endtask

   task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      sel = s;
      if (s) begin
         s_go = 1'b1; s_left = a; s_right = b;
      end else begin
         u_go = 1'b1; u_left = a; u_right = b;
      end
      @(posedge clk);
      #1;
      u_go = 1'b0;
      s_go = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit chk_busy, output int lat);
      lat = 0;
      while (m_done !== 1'b1 && lat < LIMIT) begin
         if (chk_busy) chk({tag, " busy"}, m_busy, 64'd1);
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= LIMIT) chk({tag, " timeout"}, 64'd0, 64'd1);
   endtask

   task automatic run_check(input string tag, input bit s, input logic [31:0] a,
                            input logic [31:0] b, input bit chk_busy);
      logic [31:0] eq, er;
      bit          edz;
      int          lat, elat;
      model(s, a, b, eq, er, edz);
      elat = (b == 32'd0 || a == 32'd0) ? 0 : ((s ? ITERS_S : ITERS_U) + 1);
      start_op(s, a, b);
      wait_done(tag, chk_busy, lat);
      chk({tag, " lat"}, lat, elat);
      chk({tag, " q"}, m_q, eq);
      chk({tag, " r"}, m_r, er);
      chk({tag, " dbz"}, m_dbz, edz);
      chk({tag, " busy_at_done"}, m_busy, 64'd0);
      @(posedge clk);
      #1;
      chk({tag, " pulse"}, m_done, 64'd0);
   endtask

   function automatic logic [31:0] rnd_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = $urandom_range(0, 15);
         default: v = $urandom();
      endcase
      return v;
   endfunction

   initial begin : main
      logic [31:0] eq, er;
      bit          edz;
      int          lat, ndone;
      logic [31:0] pa [3];
      logic [31:0] pb [3];
      pa[0] = 32'd1000;  pb[0] = 32'd33;
      pa[1] = 32'hDEAD_BEEF; pb[1] = 32'd12345;
      pa[2] = 32'd77;    pb[2] = 32'd80;

      sel = 1'b0;
      u_go = 1'b0; s_go = 1'b0;
      u_left = '0; u_right = '0; s_left = '0; s_right = '0;
      reset = 1'b1;
      #12;
      chk("rst done", {u_done, s_done}, 64'd0);
      chk("rst busy", {u_busy, s_busy}, 64'd0);
      chk("rst dbz", {u_dbz, s_dbz}, 64'd0);
      chk("rst q", {u_q, s_q}, 64'd0);
      chk("rst r", {u_r, s_r}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic unsigned and signed, with busy checked every in-flight cycle.
      run_check("u 100/7", 1'b0, 32'd100, 32'd7, 1'b1);
      run_check("s 100/7", 1'b1, 32'd100, 32'd7, 1'b1);
      run_check("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_check("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run_check("s MIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_check("u MIN/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_check("u x/0", 1'b0, 32'h1234, 32'd0, 1'b0);
      run_check("s x/0", 1'b1, 32'h1234, 32'd0, 1'b0);
      run_check("u 0/5", 1'b0, 32'd0, 32'd5, 1'b0);
      run_check("s 0/-5", 1'b1, 32'd0, 32'hFFFF_FFFB, 1'b0);
      run_check("u small/big", 1'b0, 32'd5, 32'hFFFF_FFF0, 1'b0);

      // go while busy is ignored.
      start_op(1'b0, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      @(negedge clk);
      u_go = 1'b1; u_left = 32'd50; u_right = 32'd3;
      @(negedge clk);
      u_go = 1'b0;
      wait_done("busy_go", 1'b0, lat);
      chk("busy_go q", u_q, 64'd14);
      chk("busy_go r", u_r, 64'd2);
      @(posedge clk);
      #1;
      chk("busy_go no_second", {u_done, u_busy}, 64'd0);

      // Reset in the middle of CALC aborts without a done pulse.
      start_op(1'b0, 32'd100000, 32'd7);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("abort done", u_done, 64'd0);
      chk("abort busy", u_busy, 64'd0);
      chk("abort q", u_q, 64'd0);
      chk("abort r", u_r, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (ITERS_U + 4) begin
         @(posedge clk);
         #1;
         if (u_done === 1'b1) ndone++;
      end
      chk("abort no_done", ndone, 64'd0);
      run_check("u 9/4", 1'b0, 32'd9, 32'd4, 1'b0);

      // go held high: each next operation accepted in the previous done cycle.
      @(negedge clk);
      sel = 1'b0;
      u_go = 1'b1; u_left = pa[0]; u_right = pb[0];
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         wait_done("held", 1'b0, lat);
         model(1'b0, pa[k], pb[k], eq, er, edz);
         chk("held lat", lat, ITERS_U + 1);
         chk("held q", u_q, eq);
         chk("held r", u_r, er);
         if (k < 2) begin
            u_left = pa[k+1]; u_right = pb[k+1];
         end else begin
            u_go = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      chk("held idle", {u_done, u_busy}, 64'd0);

      // Random pairs on both instances.
      for (int i = 0; i < 300; i++) begin
         run_check("u rnd", 1'b0, rnd_operand(), rnd_operand(), 1'b0);
         run_check("s rnd", 1'b1, rnd_operand(), rnd_operand(), 1'b0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
